dct_2d_sched: RTL and testbench

- Sequencer for the two-stage 2D DCT column datapath.
- Accepts one row vector at a time over a valid/ready handshake and pulses a load strobe so the datapath input register captures the row.
- Then steps the coefficient index 0..DATA_DEPTH-1 into the stage1/stage2 coefficient selectors, one index per cycle.
- Tracks in-flight results through the fixed datapath latency, tags each result, and limits issue with downstream credits, since the datapath cannot stall.

---
 rtl/dct_2d_sched.sv | 146 ++++++++++++++
 tb/tb_dct_2d_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_2d_sched.sv
// Row/coefficient sequencer for the two-stage 2D DCT column datapath.
// Issues one coefficient index per cycle under credit control and tags results.
module dct_2d_sched #(
    parameter int DATA_DEPTH = 8,
    parameter int PIPE_LAT   = 4,
    parameter int CREDITS    = 8,
    parameter int IDX_W      = $clog2(DATA_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dp_load,
    output logic             dp_issue,
    output logic [IDX_W-1:0] dp_coeff_idx,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_coeff_idx,
    output logic [IDX_W-1:0] res_row_idx,
    output logic             res_block_last,
    output logic             block_done,
    input  logic             credit_return,
    output logic             busy,
    output logic             err_credit
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_DEPTH - 1);
    localparam logic [CW-1:0] CFULL = CW'(CREDITS);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] row;
        logic             last;
    } tag_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_k;
    logic [IDX_W-1:0] r_row_cnt;
    logic [IDX_W-1:0] r_row_tag;
    logic [CW-1:0]    r_credit;
    logic             r_err;
    tag_t             r_pipe [PIPE_LAT];

    logic w_accept;
    logic w_k_last;
    logic w_cr_full;
    tag_t w_tag_in;
    logic w_any_valid;

    assign in_ready     = (r_state == S_IDLE) & ~flush;
    assign w_accept     = in_valid & in_ready;
    assign dp_load      = w_accept;
    assign dp_issue     = (r_state == S_ISSUE) & (r_credit != '0) & ~flush;
    assign dp_coeff_idx = dp_issue ? r_k : '0;
    assign w_k_last     = (r_k == LAST);
    assign w_cr_full    = (r_credit == CFULL);

    always_comb begin
        w_tag_in = '0;
        if (dp_issue) begin
            w_tag_in.v    = 1'b1;
            w_tag_in.idx  = r_k;
            w_tag_in.row  = r_row_tag;
            w_tag_in.last = w_k_last & (r_row_tag == LAST);
        end
    end

    always_comb begin
        w_any_valid = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            w_any_valid = w_any_valid | r_pipe[i].v;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_row_cnt <= '0;
            r_row_tag <= '0;
            r_credit  <= CFULL;
            r_err     <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_row_cnt <= '0;
            r_credit  <= CFULL;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_row_tag <= r_row_cnt;
                        r_k       <= '0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dp_issue) begin
                        if (w_k_last) begin
                            r_state   <= S_IDLE;
                            r_row_cnt <= (r_row_cnt == LAST) ? '0 : r_row_cnt + 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Simultaneous issue and return cancel; a return into a full pool is an error.
            if (dp_issue & ~credit_return) begin
                r_credit <= r_credit - CW'(1);
            end else if (~dp_issue & credit_return) begin
                if (w_cr_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_credit <= r_credit + CW'(1);
                end
            end

            r_pipe[0] <= w_tag_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign res_valid      = r_pipe[PIPE_LAT-1].v;
    assign res_coeff_idx  = r_pipe[PIPE_LAT-1].idx;
    assign res_row_idx    = r_pipe[PIPE_LAT-1].row;
    assign res_block_last = r_pipe[PIPE_LAT-1].last;
    assign block_done     = res_valid & res_block_last;
    assign busy           = (r_state == S_ISSUE) | w_any_valid;
    assign err_credit     = r_err;

endmodule

// File: tb/tb_dct_2d_sched.sv
// Bench for dct_2d_sched: directed scenarios plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_dct_2d_sched;

    localparam int D  = 8;
    localparam int PL = 4;
    localparam int CR = 8;
    localparam int IW = 3;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          dp_load;
    logic          dp_issue;
    logic [IW-1:0] dp_coeff_idx;
    logic          res_valid;
    logic [IW-1:0] res_coeff_idx;
    logic [IW-1:0] res_row_idx;
    logic          res_block_last;
    logic          block_done;
    logic          credit_return;
    logic          busy;
    logic          err_credit;

    dct_2d_sched #(.DATA_DEPTH(D), .PIPE_LAT(PL), .CREDITS(CR)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .dp_load(dp_load), .dp_issue(dp_issue),
        .dp_coeff_idx(dp_coeff_idx),
        .res_valid(res_valid), .res_coeff_idx(res_coeff_idx),
        .res_row_idx(res_row_idx), .res_block_last(res_block_last),
        .block_done(block_done), .credit_return(credit_return),
        .busy(busy), .err_credit(err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int due;
        int idx;
        int row;
        bit last;
    } res_t;

    // Model: an active row with its next index, a credit pool, and a
    // queue of results each stamped with the cycle it must appear.
    bit   m_active;
    int   m_nxt;
    int   m_row;
    int   m_tag;
    int   m_cred;
    bit   m_err;
    int   cyc;
    res_t q[$];

    logic s_load, s_issue, s_ready, s_rv, s_bd, s_busy, s_err;
    int   s_idx, s_ridx, s_rrow;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_nxt    = 0;
        m_row    = 0;
        m_tag    = 0;
        m_cred   = CR;
        m_err    = 1'b0;
        q.delete();
    endtask

    task automatic check_and_update();
        bit   e_ready, e_load, e_issue, e_rv;
        int   e_idx;
        res_t e_r;
        e_ready = !m_active && !flush;
        e_load  = in_valid && e_ready;
        e_issue = m_active && (m_cred > 0) && !flush;
        e_idx   = e_issue ? m_nxt : 0;
        e_rv    = (q.size() > 0) && (q[0].due == cyc);
        e_r     = e_rv ? q[0] : '{0, 0, 0, 1'b0};

        chk("in_ready", in_ready, e_ready);
        chk("dp_load", dp_load, e_load);
        chk("dp_issue", dp_issue, e_issue);
        chk("dp_coeff_idx", dp_coeff_idx, e_idx);
        chk("res_valid", res_valid, e_rv);
        if (e_rv) begin
            chk("res_coeff_idx", res_coeff_idx, e_r.idx);
            chk("res_row_idx", res_row_idx, e_r.row);
            chk("res_block_last", res_block_last, e_r.last);
        end
        chk("block_done", block_done, e_rv && e_r.last);
        chk("busy", busy, m_active || (q.size() > 0));
        chk("err_credit", err_credit, m_err);

        s_load  = dp_load;
        s_issue = dp_issue;
        s_idx   = dp_coeff_idx;
        s_ready = in_ready;
        s_rv    = res_valid;
        s_ridx  = res_coeff_idx;
        s_rrow  = res_row_idx;
        s_bd    = block_done;
        s_busy  = busy;
        s_err   = err_credit;

        if (e_rv) void'(q.pop_front());
        if (flush) begin
            m_active = 1'b0;
            m_nxt    = 0;
            m_row    = 0;
            m_cred   = CR;
            q.delete();
        end else begin
            if (credit_return && !e_issue && m_cred == CR)
                m_err = 1'b1;
            else
                m_cred = m_cred + (credit_return ? 1 : 0) - (e_issue ? 1 : 0);
            if (e_issue) begin
                q.push_back('{cyc + PL, m_nxt, m_tag,
                              (m_nxt == D - 1) && (m_tag == D - 1)});
                if (m_nxt == D - 1) begin
                    m_active = 1'b0;
                    m_row    = (m_row + 1) % D;
                end else begin
                    m_nxt++;
                end
            end
            if (e_load) begin
                m_active = 1'b1;
                m_nxt    = 0;
                m_tag    = m_row;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit v, input bit f, input bit c);
        in_valid      = v;
        flush         = f;
        credit_return = c;
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        in_valid      = 1'b0;
        flush         = 1'b0;
        credit_return = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst dp_issue", dp_issue, 0);
        chk("rst dp_load", dp_load, 0);
        chk("rst res_valid", res_valid, 0);
        chk("rst block_done", block_done, 0);
        chk("rst busy", busy, 0);
        chk("rst err_credit", err_credit, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic single_row();
        step(1, 0, 0);
        chk("row load", s_load, 1);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0);
            if (i <= 8) begin
                chk("row issue", s_issue, 1);
                chk("row idx", s_idx, i - 1);
                chk("row ready low", s_ready, 0);
            end
            if (i == 9) chk("row ready back", s_ready, 1);
            if (i >= 5) begin
                chk("row res_valid", s_rv, 1);
                chk("row res idx", s_ridx, i - 5);
                chk("row res row", s_rrow, 0);
            end
        end
    endtask

    initial begin
        int nres;
        int nbd;
        int seen;
        reset         = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        credit_return = 1'b0;
        cyc           = 0;
        model_reset();
        @(negedge clk);
        chk("init in_ready", in_ready, 1);
        chk("init dp_issue", dp_issue, 0);
        chk("init res_valid", res_valid, 0);
        chk("init busy", busy, 0);
        chk("init err", err_credit, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        single_row();

        // Pool is now empty: the next row stalls until a credit returns.
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            chk("stall no issue", s_issue, 0);
        end
        step(0, 0, 1);
        chk("no bypass", s_issue, 0);
        step(0, 0, 0);
        chk("credit issue", s_issue, 1);
        chk("credit idx", s_idx, 0);
        step(0, 0, 0);
        chk("stall again", s_issue, 0);
        step(0, 1, 0);

        nres = 0;
        nbd  = 0;
        for (int i = 0; i < 400 && nres < 64; i++) begin
            step(1, 0, res_valid);
            if (s_rv) nres++;
            if (s_bd) begin
                nbd++;
                chk("bd row", s_rrow, 7);
                chk("bd idx", s_ridx, 7);
            end
        end
        chk("block results", nres, 64);
        chk("block_done count", nbd, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, res_valid);
            if (s_rv && seen == 0) begin
                seen = 1;
                chk("wrap row tag", s_rrow, 0);
            end
        end
        chk("wrap row seen", seen, 1);
        step(0, 1, 0);

        // Return coinciding with issue at count 3 must leave 3.
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("last credit issue", s_issue, 1);
        step(0, 0, 0);
        chk("credits exhausted", s_issue, 0);
        step(0, 1, 0);

        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 1, 0);
        chk("flush no issue", s_issue, 0);
        step(0, 0, 0);
        chk("post flush rv", s_rv, 0);
        chk("post flush ready", s_ready, 1);
        chk("post flush busy", s_busy, 0);

        step(0, 0, 1);
        step(0, 0, 0);
        chk("err set", s_err, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("err sticky", s_err, 1);

        for (int i = 0; i < 3000; i++) begin
            bit v, f, c;
            v = ($urandom_range(0, 1) == 1);
            f = ($urandom_range(0, 31) == 0);
            c = res_valid ? ($urandom_range(0, 3) != 0)
                          : ($urandom_range(0, 15) == 0);
            step(v, f, c);
            if ($urandom_range(0, 499) == 0) mid_reset();
        end

        step(0, 1, 0);
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        mid_reset();
        single_row();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
